// File: rtl/pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pattern_pkg
// Description : Shared types and defaults for the stimulus pattern path
//               (pattern_gen / pattern_checker and their benches).
//               - chk_state_t : checker FSM state encoding
//               - *_DEF       : default parameter values
// Revision    : 1.0 - initial release
// ============================================================================
package pattern_pkg;

    localparam int STIM_SIZE_DEF = 8;
    localparam int CYCLES_DEF    = 8;
    localparam int ERR_W_DEF     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

endpackage
`default_nettype wire

// File: rtl/pattern_checker.sv
`default_nettype none
// ============================================================================
// Module      : pattern_checker
// Description : Checks that stim_pattern counts 0,1,..,2^STIM_SIZE-1,0,..
//               without skips or repeats. Locks on the first 0, counts
//               completed sweeps and mismatches, and flags done/pass after
//               CYCLES full sweeps.
// Ports       : clk          - rising-edge clock
//               rst          - asynchronous active-high reset
//               enable       - arm checker (low returns to IDLE)
//               sample_valid - stim_pattern carries a new sample
//               stim_pattern - pattern under check
//               locked       - synchronised to 0 and comparing
//               mismatch     - one-cycle pulse: last sample != expected
//               expected     - value required on the next accepted sample
//               sweep_count  - completed sweeps
//               err_count    - saturating mismatch count
//               done         - CYCLES sweeps completed
//               pass         - valid with done: no mismatches seen
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_checker
    import pattern_pkg::*;
#(
    parameter int STIM_SIZE = STIM_SIZE_DEF,
    parameter int CYCLES    = CYCLES_DEF,
    parameter int ERR_W     = ERR_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         sample_valid,
    input  logic [STIM_SIZE-1:0]         stim_pattern,
    output logic                         locked,
    output logic                         mismatch,
    output logic [STIM_SIZE-1:0]         expected,
    output logic [$clog2(CYCLES+1)-1:0]  sweep_count,
    output logic [ERR_W-1:0]             err_count,
    output logic                         done,
    output logic                         pass
);

    localparam int                      c_SWEEP_W   = $clog2(CYCLES + 1);
    localparam logic [STIM_SIZE-1:0]    c_STIM_MAX  = '1;
    localparam logic [STIM_SIZE-1:0]    c_STIM_ONE  = STIM_SIZE'(1);
    localparam logic [ERR_W-1:0]        c_ERR_MAX   = '1;
    localparam logic [c_SWEEP_W-1:0]    c_SWEEP_END = c_SWEEP_W'(CYCLES);

    chk_state_t             r_state;
    logic                   r_locked;
    logic                   r_mismatch;
    logic [STIM_SIZE-1:0]   r_expected;
    logic [c_SWEEP_W-1:0]   r_sweep;
    logic [ERR_W-1:0]       r_err;
    logic                   r_done;
    logic                   r_pass;

    chk_state_t             w_state_nxt;
    logic                   w_locked_nxt;
    logic                   w_mismatch_nxt;
    logic [STIM_SIZE-1:0]   w_expected_nxt;
    logic [c_SWEEP_W-1:0]   w_sweep_nxt;
    logic [ERR_W-1:0]       w_err_nxt;
    logic                   w_done_nxt;
    logic                   w_pass_nxt;

    logic                   w_is_err;
    logic [ERR_W-1:0]       w_err_after;
    logic [c_SWEEP_W-1:0]   w_sweep_inc;

    // Error count as it stands after the current sample; saturates at all-ones.
    assign w_is_err    = (stim_pattern != r_expected);
    assign w_err_after = (w_is_err && (r_err != c_ERR_MAX)) ? r_err + 1'b1 : r_err;
    assign w_sweep_inc = r_sweep + 1'b1;

    always_comb begin
        w_state_nxt    = r_state;
        w_locked_nxt   = r_locked;
        w_mismatch_nxt = 1'b0;
        w_expected_nxt = r_expected;
        w_sweep_nxt    = r_sweep;
        w_err_nxt      = r_err;
        w_done_nxt     = r_done;
        w_pass_nxt     = r_pass;

        if (!enable) begin
            // Counters stay put so they can be read out after a stop.
            w_state_nxt  = IDLE;
            w_locked_nxt = 1'b0;
            w_done_nxt   = 1'b0;
            w_pass_nxt   = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt    = SYNC;
                    w_locked_nxt   = 1'b0;
                    w_expected_nxt = '0;
                    w_sweep_nxt    = '0;
                    w_err_nxt      = '0;
                    w_done_nxt     = 1'b0;
                    w_pass_nxt     = 1'b0;
                end
                SYNC: begin
                    // Anything other than 0 before lock is simply discarded.
                    if (sample_valid && (stim_pattern == '0)) begin
                        w_state_nxt    = CHECK;
                        w_locked_nxt   = 1'b1;
                        w_expected_nxt = c_STIM_ONE;
                    end
                end
                CHECK: begin
                    if (sample_valid) begin
                        // Resync to the observed value so one skip/repeat
                        // costs exactly one error.
                        w_expected_nxt = stim_pattern + c_STIM_ONE;
                        w_mismatch_nxt = w_is_err;
                        w_err_nxt      = w_err_after;
                        if (stim_pattern == c_STIM_MAX) begin
                            w_sweep_nxt = w_sweep_inc;
                            if (w_sweep_inc == c_SWEEP_END) begin
                                w_state_nxt  = DONE;
                                w_locked_nxt = 1'b0;
                                w_done_nxt   = 1'b1;
                                w_pass_nxt   = (w_err_after == '0);
                            end
                        end
                    end
                end
                DONE: begin
                    w_state_nxt = DONE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_locked   <= 1'b0;
            r_mismatch <= 1'b0;
            r_expected <= '0;
            r_sweep    <= '0;
            r_err      <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_locked   <= w_locked_nxt;
            r_mismatch <= w_mismatch_nxt;
            r_expected <= w_expected_nxt;
            r_sweep    <= w_sweep_nxt;
            r_err      <= w_err_nxt;
            r_done     <= w_done_nxt;
            r_pass     <= w_pass_nxt;
        end
    end

    assign locked      = r_locked;
    assign mismatch    = r_mismatch;
    assign expected    = r_expected;
    assign sweep_count = r_sweep;
    assign err_count   = r_err;
    assign done        = r_done;
    assign pass        = r_pass;

endmodule
`default_nettype wire
